regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (DataD/AddrD/RegWEn) between two writeback sources:
//   - P: in-order pipeline writeback;
//   - M: multicycle execution unit (mul/div).
//  Tracks registers with an outstanding M result in a busy scoreboard, so decode can stall on RAW/WAW hazards.
//  Sits between the WB stage / multicycle unit and the register file.
// PARAMETERS
//  DATA_WIDTH    32  register data width
//  STARVE_LIMIT  4   consecutive M-waiting cycles before M is forced to win (1..2**CNT_WIDTH-1)
//  CNT_WIDTH     3   width of the starvation counter
//  STAT_WIDTH    16  width of the statistics counters (ARB_STATS_EN only)
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst_n      in   1           asynchronous active-low reset
//  PValid     in   1           pipeline writeback request
//  PAddr      in   5           pipeline destination register
//  PData      in   DATA_WIDTH  pipeline writeback data
//  PReady     out  1           pipeline request accepted this cycle (0 = stall WB)
//  MValid     in   1           multicycle writeback request
//  MAddr      in   5           multicycle destination register
//  MData      in   DATA_WIDTH  multicycle writeback data
//  MReady     out  1           multicycle request accepted this cycle
//  MIssue     in   1           multicycle op issued this cycle (reserve MIssueAddr)
//  MIssueAddr in   5           destination register of the issued op
//  AddrA      in   5           decode source-1 query
//  AddrB      in   5           decode source-2 query
//  AddrQ      in   5           decode destination query
//  BusyA      out  1           AddrA has a pending M result (combinational)
//  BusyB      out  1           AddrB has a pending M result (combinational)
//  BusyQ      out  1           AddrQ has a pending M result (WAW guard; combinational)
//  RegWEn     out  1           register-file write enable (registered)
//  AddrD      out  5           register-file write address (registered)
//  DataD      out  DATA_WIDTH  register-file write data (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): RegWEn=0, AddrD=0, DataD=0, Busy[31:0]=0, starve counter=0.
//    Reset mid-operation discards pending reservations; PReady/MReady follow the combinational rules below.
//  - Grant, combinational:
//    - P only: P wins. M only: M wins.
//    - Both valid: P wins unless starve==STARVE_LIMIT, then M wins.
//    - PReady = PValid & Pwin; MReady = MValid & Mwin.
//  - Starve counter:
//    - increments (saturating at STARVE_LIMIT) each cycle MValid & ~MReady;
//    - clears on an M grant or when MValid=0.
//  - Output register:
//    - on posedge, a winner loads AddrD/DataD from the winner;
//    - RegWEn=1 only if the winner's address != 0;
//    - no grant -> RegWEn=0, AddrD/DataD hold.
//    - Latency: request accepted in cycle N -> RegWEn high during cycle N+1; the register file captures it at that cycle's negedge.
//  - x0 requests are accepted (Ready=1) and consume the port slot, but never raise RegWEn.
//  - Scoreboard:
//    - MIssue & MIssueAddr!=0 sets Busy[MIssueAddr];
//    - an M grant clears Busy[MAddr];
//    - same address set and cleared in the same cycle -> set wins (newer op).
//    - Busy[0] is constantly 0.
//    - BusyA/B/Q read the current Busy bits (not the next-state value).
//  - P writing a register whose Busy=1 is a protocol error (decode must stall on BusyQ).
//    Checked by a simulation-only assertion; the RTL still performs the write.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs
//    - PStallCnt[STAT_WIDTH-1:0]: cycles with PValid & ~PReady;
//    - MGrantCnt[STAT_WIDTH-1:0]: M grants.
//    Both saturate at all-ones and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Reset: rst_n=0 mid-burst with Busy[5]=1 -> RegWEn=0, AddrD=0, DataD=0, BusyA(AddrA=5)=0 immediately, before the next clk edge.
//  - P alone: PValid=1, PAddr=3, PData=0xDEADBEEF -> PReady=1; next cycle RegWEn=1, AddrD=3, DataD=0xDEADBEEF.
//  - Starvation, STARVE_LIMIT=4, PValid and MValid held high:
//    - P granted in cycles 0-3; M granted in cycle 4 (PReady=0 that cycle);
//    - counter returns to 0, P granted in cycle 5.
//  - Scoreboard: MIssue with MIssueAddr=7 -> BusyA(AddrA=7)=1 next cycle; M grant with MAddr=7 -> BusyA=0 the cycle after.
//    Also: MIssue(7) in the same cycle as an M grant for MAddr=7 -> BusyA remains 1.
//  - x0: MValid=1, MAddr=0 -> MReady=1, next cycle RegWEn=0; MIssueAddr=0 never sets BusyQ(AddrQ=0).
//  - ARB_STATS_EN: the starvation run above -> PStallCnt=1, MGrantCnt=1; saturation at 0xFFFF verified with a preloaded counter.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline (P) and multicycle (M) writeback, with a busy scoreboard.
// Latency 1 (accepted in N -> RegWEn in N+1); loser sees Ready=0; P has priority until M starves. Optional: ARB_STATS_EN.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
`ifdef ARB_STATS_EN
    ,
    parameter int STAT_WIDTH   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PValid,
    input  logic [4:0]            PAddr,
    input  logic [DATA_WIDTH-1:0] PData,
    output logic                  PReady,
    input  logic                  MValid,
    input  logic [4:0]            MAddr,
    input  logic [DATA_WIDTH-1:0] MData,
    output logic                  MReady,
    input  logic                  MIssue,
    input  logic [4:0]            MIssueAddr,
    input  logic [4:0]            AddrA,
    input  logic [4:0]            AddrB,
    input  logic [4:0]            AddrQ,
    output logic                  BusyA,
    output logic                  BusyB,
    output logic                  BusyQ,
`ifdef ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] PStallCnt,
    output logic [STAT_WIDTH-1:0] MGrantCnt,
`endif
    output logic                  RegWEn,
    output logic [4:0]            AddrD,
    output logic [DATA_WIDTH-1:0] DataD
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0]  starve_q, starve_d;
    logic [31:0]           busy_q, busy_d;
    logic                  wen_q;
    logic [4:0]            addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  p_win, m_win;

    always_comb begin
        p_win = PValid & ~(MValid & (starve_q == LIMIT));
        m_win = MValid & ~p_win;
    end

    assign PReady = p_win;
    assign MReady = m_win;

    always_comb begin
        starve_d = starve_q;
        if (!MValid || m_win) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Set is applied after clear so a newly issued op keeps its reservation.
    always_comb begin
        busy_d = busy_q;
        if (m_win) begin
            busy_d[MAddr] = 1'b0;
        end
        if (MIssue && (MIssueAddr != 5'd0)) begin
            busy_d[MIssueAddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            busy_q   <= '0;
            wen_q    <= 1'b0;
            addr_q   <= 5'd0;
            data_q   <= '0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            if (p_win) begin
                wen_q  <= (PAddr != 5'd0);
                addr_q <= PAddr;
                data_q <= PData;
            end else if (m_win) begin
                wen_q  <= (MAddr != 5'd0);
                addr_q <= MAddr;
                data_q <= MData;
            end else begin
                wen_q  <= 1'b0;
            end
        end
    end

    assign RegWEn = wen_q;
    assign AddrD  = addr_q;
    assign DataD  = data_q;
    assign BusyA  = busy_q[AddrA];
    assign BusyB  = busy_q[AddrB];
    assign BusyQ  = busy_q[AddrQ];

`ifdef ARB_STATS_EN
    logic [STAT_WIDTH-1:0] pstall_q, mgrant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstall_q <= '0;
            mgrant_q <= '0;
        end else begin
            if (PValid && !p_win && (pstall_q != '1)) begin
                pstall_q <= pstall_q + 1'b1;
            end
            if (m_win && (mgrant_q != '1)) begin
                mgrant_q <= mgrant_q + 1'b1;
            end
        end
    end

    assign PStallCnt = pstall_q;
    assign MGrantCnt = mgrant_q;
`endif

`ifndef SYNTHESIS
    // Decode must stall on BusyQ; a P write to a reserved register would be overwritten out of order.
    p_write_busy_reg: assert property (@(posedge clk) disable iff (!rst_n) !(p_win && busy_q[PAddr]));
`endif

endmodule
